// File: rtl/pipe_pkg.sv
// Shared constants for the skid-buffered pipeline register.
// Defaults and occupancy encoding used by pipe_skid_reg.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ZOB_DEF    = 1;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occ_enc(
    input logic m,
    input logic s
  );
    logic [1:0] r;
    r = OCC_EMPTY;
    unique case ({m, s})
      2'b10:   r = OCC_ONE;
      2'b11:   r = OCC_FULL;
      default: r = OCC_EMPTY;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One held pipeline entry: valid bit plus data register.
// Ports: clk, rst, clr (valid only), ld, d -> valid, data.
module pipe_entry #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (ld) begin
      valid <= 1'b1;
    end
  end

  // clr drops validity but keeps the payload visible
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (ld && !clr) begin
      data <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with flush and stall counter.
// in_* upstream, out_* downstream, occupancy, stall_cnt status.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ZERO_ON_BUBBLE = ZOB_DEF,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;

  logic              up;
  logic              dn;
  logic              main_ld_skid;
  logic              main_ld_in;
  logic              main_ld;
  logic              main_clr;
  logic              skid_ld;
  logic              skid_clr;
  logic              skid_nxt;
  logic [DATA_W-1:0] main_din;
  logic              rdy_q;

  assign up = in_valid & rdy_q & ~flush;
  assign dn = main_v & out_ready & ~flush;

  assign main_ld_skid = dn & skid_v;
  assign main_ld_in   = up & (~main_v | (dn & ~skid_v));
  assign main_ld      = main_ld_skid | main_ld_in;
  assign main_clr     = flush | (dn & ~skid_v & ~up);
  assign main_din     = main_ld_skid ? skid_d : in_data;

  assign skid_ld  = up & ~main_ld_in;
  assign skid_clr = flush | (main_ld_skid & ~skid_ld);

  always_comb begin
    skid_nxt = skid_v;
    if (skid_clr) begin
      skid_nxt = 1'b0;
    end else if (skid_ld) begin
      skid_nxt = 1'b1;
    end
  end

  pipe_entry #(.DATA_W(DATA_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clr   (main_clr),
    .ld    (main_ld),
    .d     (main_din),
    .valid (main_v),
    .data  (main_d)
  );

  pipe_entry #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clr   (skid_clr),
    .ld    (skid_ld),
    .d     (in_data),
    .valid (skid_v),
    .data  (skid_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= ~skid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = main_v;
  assign occupancy = occ_enc(main_v, skid_v);

  generate
    if (ZERO_ON_BUBBLE != 0) begin : g_zob
      assign out_data = main_v ? main_d : '0;
    end else begin : g_hold
      assign out_data = main_d;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg (DATA_W=32, CNT_W=4).
// Vector table plus hand sequences for bubble and stall cases.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready,  in_ready0;
  logic        out_valid, out_valid0;
  logic [31:0] out_data,  out_data0;
  logic [1:0]  occupancy, occupancy0;
  logic [3:0]  stall_cnt, stall_cnt0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(32), .ZERO_ON_BUBBLE(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.DATA_W(32), .ZERO_ON_BUBBLE(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occupancy0), .stall_cnt(stall_cnt0)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_ir;
    logic [1:0]  e_occ;
    logic        cs;
    logic [3:0]  e_st;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic iv,
                     input logic [31:0] d, input logic ordy,
                     input logic ov, input logic [31:0] od,
                     input logic ir, input logic [1:0] occ,
                     input logic cs, input logic [3:0] st);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ov = ov; v.e_od = od; v.e_ir = ir; v.e_occ = occ;
    v.cs = cs; v.e_st = st;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [31:0] d, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //  rst f iv d      ordy ov od     ir occ cs st
    add(1, 0, 0, 32'h0, 0,   0, 32'h0, 1, 0,  1, 0);
    add(0, 0, 1, 32'h1, 1,   1, 32'h1, 1, 1,  0, 0);
    add(0, 0, 1, 32'h2, 1,   1, 32'h2, 1, 1,  0, 0);
    add(0, 0, 1, 32'h3, 1,   1, 32'h3, 1, 1,  0, 0);
    add(0, 0, 0, 32'h0, 1,   0, 32'h0, 1, 0,  0, 0);
    add(0, 0, 1, 32'hA, 0,   1, 32'hA, 1, 1,  0, 0);
    add(0, 0, 1, 32'hB, 0,   1, 32'hA, 0, 2,  0, 0);
    add(0, 0, 1, 32'hD, 0,   1, 32'hA, 0, 2,  0, 0);
    add(0, 0, 0, 32'h0, 1,   1, 32'hB, 1, 1,  0, 0);
    add(0, 0, 0, 32'h0, 1,   0, 32'h0, 1, 0,  0, 0);
    add(0, 0, 1, 32'hA, 0,   1, 32'hA, 1, 1,  0, 0);
    add(0, 0, 1, 32'hB, 0,   1, 32'hA, 0, 2,  0, 0);
    add(0, 1, 1, 32'hC, 0,   0, 32'h0, 1, 0,  0, 0);
    add(0, 0, 0, 32'h0, 1,   0, 32'h0, 1, 0,  0, 0);
    add(0, 0, 1, 32'h1, 0,   1, 32'h1, 1, 1,  0, 0);
    add(0, 0, 1, 32'h2, 0,   1, 32'h1, 0, 2,  0, 0);
    add(1, 0, 1, 32'h9, 0,   0, 32'h0, 1, 0,  1, 0);
    add(0, 0, 1, 32'h7, 1,   1, 32'h7, 1, 1,  0, 0);
    add(0, 0, 0, 32'h0, 1,   0, 32'h0, 1, 0,  0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d out_data", i), out_data, tbl[i].e_od);
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
      chk($sformatf("v%0d occ0", i), 32'(occupancy0), 32'(tbl[i].e_occ));
      if (tbl[i].cs)
        chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].e_st));
    end

    // bubble: zeroed vs held payload
    drive(1, 0, 0, 32'h0, 0);
    drive(0, 0, 1, 32'h55, 1);
    chk("bub ov", 32'(out_valid0), 32'h1);
    chk("bub od0 live", out_data0, 32'h55);
    drive(0, 0, 0, 32'h0, 1);
    chk("bub ov1", 32'(out_valid), 32'h0);
    chk("bub od zero", out_data, 32'h0);
    chk("bub ov0", 32'(out_valid0), 32'h0);
    chk("bub od0 held", out_data0, 32'h55);

    // stall counter saturation and flush immunity
    drive(1, 0, 0, 32'h0, 0);
    drive(0, 0, 1, 32'h11, 0);
    chk("st start", 32'(stall_cnt), 32'h0);
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, 32'h0, 0);
      chk($sformatf("st c%0d", k), 32'(stall_cnt), (k > 15) ? 32'd15 : 32'(k));
    end
    drive(0, 1, 0, 32'h0, 0);
    chk("st flush cnt", 32'(stall_cnt), 32'hF);
    chk("st flush ov", 32'(out_valid), 32'h0);
    drive(0, 0, 0, 32'h0, 0);
    chk("st hold", 32'(stall_cnt), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits, legal range 1..256.
REQ-002 Parameter ZERO_ON_BUBBLE, default 1: 1 forces out_data to zero whenever out_valid=0; 0 leaves the held data visible.
REQ-003 Parameter CNT_W, default 16: width of the stall counter.
REQ-004 Port clk, input, 1: clock, rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port flush, input, 1: synchronous discard of all held entries (branch or exception kill).
REQ-007 Port in_valid, input, 1: upstream offers in_data.
REQ-008 Port in_ready, output, 1: the stage can accept; this signal is registered.
REQ-009 Port in_data, input, DATA_W: upstream payload.
REQ-010 Port out_valid, output, 1: out_data is valid.
REQ-011 Port out_ready, input, 1: downstream accepts.
REQ-012 Port out_data, output, DATA_W: downstream payload.
REQ-013 Port occupancy, output, 2: number of held entries, 0..2.
REQ-014 Port stall_cnt, output, CNT_W: saturating count of backpressure cycles.

Function
REQ-015 The block SHALL hold two entries, MAIN (drives out_*) and SKID, each with a valid bit.
REQ-016 An upstream transfer SHALL occur when in_valid=1 and in_ready=1 at a rising edge.
REQ-017 A downstream transfer SHALL occur when out_valid=1 and out_ready=1 at a rising edge.
REQ-018 in_ready SHALL equal the registered value of NOT SKID.valid.
REQ-019 out_valid SHALL equal MAIN.valid, and out_data SHALL equal MAIN.data (subject to REQ-002).
REQ-020 Latency from upstream transfer to out_valid SHALL be 1 cycle when MAIN is empty or draining in that cycle.
REQ-021 Incoming data SHALL be written to MAIN when MAIN is empty, or when MAIN is draining and SKID is empty; otherwise it SHALL be written to SKID.
REQ-022 When MAIN drains and SKID is valid, SKID SHALL move to MAIN in the same edge, and any simultaneous input SHALL go to SKID.
REQ-023 Order SHALL be strict FIFO; no entry is ever dropped or duplicated except by flush.
REQ-024 When full (occupancy=2), the block SHALL accept nothing, and in_ready SHALL be 0.
REQ-025 Full throughput SHALL hold: with out_ready held at 1, one transfer per cycle with occupancy never exceeding 1.
REQ-026 flush SHALL clear both valid bits at the edge and discard any same-cycle upstream transfer; flush has priority over all handshakes.
REQ-027 In the cycle after a flush, in_ready SHALL be 1, out_valid SHALL be 0, and occupancy SHALL be 0.
REQ-028 flush SHALL NOT clear stall_cnt.
REQ-029 stall_cnt SHALL increment each cycle with out_valid=1 and out_ready=0, and SHALL saturate at all-ones without wrap.
REQ-030 Data registers SHALL load only on a write, with no toggling on idle cycles.

Reset
REQ-031 On rst, at the next edge: MAIN.valid=0, SKID.valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
REQ-032 rst SHALL override flush and all handshakes.
REQ-033 A mid-transfer rst SHALL discard all held data.
REQ-034 While rst is asserted, no transfer SHALL be recorded.

Structure
REQ-035 A shared package pipe_pkg SHALL hold the ZERO_ON_BUBBLE default, the occupancy encoding constants (EMPTY=0, ONE=1, FULL=2), and the DATA_W default.
REQ-036 A single sub-module pipe_entry (valid + DATA_W data register with load/clear) SHALL be instantiated twice, for MAIN and SKID.
REQ-037 The control logic (write select, in_ready, occupancy, stall_cnt) SHALL reside in pipe_skid_reg.

Verification (DATA_W=32, CNT_W=4)
REQ-038 Streaming: in_valid=1 with data 0x1,0x2,0x3 and out_ready=1 -> out_data 0x1,0x2,0x3 on cycles 1,2,3; occupancy ≤1; in_ready is constantly 1.
REQ-039 Backpressure: out_ready=0 while 0xA,0xB are offered -> occupancy=2 and in_ready=0 the next cycle; out_ready=1 -> 0xA then 0xB, with no loss.
REQ-040 Flush while full, with in_valid=1 carrying 0xC -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xC never appears.
REQ-041 Bubble: ZERO_ON_BUBBLE=1, draining last entry 0x55 -> out_data=0x0 the next cycle; ZERO_ON_BUBBLE=0 -> out_data stays 0x55 with out_valid=0.
REQ-042 Stall counter: out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt=0xF and held, not wrapping; a flush leaves it at 0xF.
REQ-043 Reset while occupancy=2 -> next cycle all outputs per REQ-031; the first post-reset input 0x7 appears after 1 cycle.
